msx_audio_mixer: RTL and testbench
==================================

// Module: msx_audio_mixer
// PURPOSE
// - Parametrised successor to the fixed two-source mix/compress path in the MSX top level.
// - Sums CHANNELS signed device sources with per-channel gain and mute, plus keybeep and tape click.
// - Sequential, one multiply-accumulate per clock; then hard-clip or soft-compress to OUT_W.
// - Sits between devices/slot sound outputs and the top-level audio port.
// PARAMETERS
// - CHANNELS  4   number of mixed source channels (1..16)
// - IN_W      16  signed width of each channel input
// - GAIN_W    4   unsigned gain width; gain/8 scaling, UNITY_GAIN=8
// - OUT_W     16  signed output width
// PORTS
// - clk          in   1              system clock (single clock domain)
// - reset        in   1              synchronous, active-high reset
// - ce_sample    in   1              sample strobe, one clk wide
// - ch_in        in   CHANNELS*IN_W  signed channel samples, ch0 in LSBs
// - ch_gain      in   CHANNELS*GAIN_W  per-channel gain, ch0 in LSBs
// - ch_mute      in   CHANNELS       1 = channel contributes 0
// - keybeep      in   1              adds +KEYBEEP_LEVEL (512)
// - tape_click   in   1              adds +TAPE_LEVEL (256)
// - mode         in   1              0 = hard clip, 1 = soft compress
// - clip_clr     in   1              clears clip_flag and overrun
// - audio_out    out  OUT_W          signed mixed sample, held between updates
// - audio_valid  out  1              one-clk pulse when audio_out updates
// - busy         out  1              high while a mix is in progress
// - clip_flag    out  1              sticky: limiter altered a sample
// - overrun      out  1              sticky: ce_sample arrived while busy
// BEHAVIOUR
// - Reset values: all outputs 0, FSM in IDLE, accumulator 0. Reset mid-mix abandons the mix; no valid pulse.
// - FSM states and transitions:
//   - IDLE -> ACCUM on ce_sample. Snapshot ch_in, ch_gain, ch_mute, keybeep, tape_click and mode in the same edge.
//   - ACCUM: one channel per clk, index 0..CHANNELS-1.
//     acc += mute ? 0 : (in * $signed({1'b0,gain})) >>> 3.
//     Arithmetic shift floors toward -inf.
//   - ACCUM -> SYS after the last index. SYS: acc += 512*keybeep + 256*tape_click.
//   - SYS -> LIMIT: limiter applied, result registered.
//   - LIMIT -> OUT: audio_out <= limited value, audio_valid=1 for exactly this clk.
//   - OUT -> IDLE.
// - Latency: audio_valid asserts CHANNELS+3 clks after the ce_sample edge (7 at default).
// - busy: high from the clk after acceptance through OUT inclusive; low in IDLE.
// - ce_sample while busy (including OUT): ignored, overrun <= 1, current mix unaffected.
// - Widths: ACC_W = IN_W+GAIN_W+$clog2(CHANNELS+1)+1, signed, no internal overflow possible.
// - Limiter, with MAXP=2^(OUT_W-1)-1, MINN=-2^(OUT_W-1), KNEE=2^(OUT_W-2):
//   - mode 0: clamp to [MINN, MAXP].
//   - mode 1: |x|<=KNEE passes unchanged; else |y| = KNEE+((|x|-KNEE)>>2), sign restored, then clamp.
//     Result is symmetric for ±x.
//   - clip_flag <= 1 whenever the limited value differs from the value before limiting.
// - clip_clr and a simultaneous set event in the same clk: set wins. Same rule for overrun.
// - audio_out holds its last value between valid pulses.
// STRUCTURE
// - msx_audio_pkg holds:
//   - mixer_state_t enum {IDLE, ACCUM, SYS, LIMIT, OUT}
//   - mix_mode_t {MIX_CLIP, MIX_COMPRESS}
//   - constants KEYBEEP_LEVEL=512, TAPE_LEVEL=256, UNITY_GAIN=8
// - Sub-module msx_audio_limiter: combinational, parametrised ACC_W/OUT_W.
//   Inputs: value, mode. Outputs: limited value, changed flag.
// - Single shared multiplier; channel select by index counter.
// TESTING (CHANNELS=4, IN_W=16, GAIN_W=4, OUT_W=16)
// - Reset: hold reset 3 clks with ce_sample toggling -> all outputs 0, no audio_valid.
// - Unity: ch0=1000 gain 8, others gain 0, ce_sample.
//   -> audio_out=1000, audio_valid exactly 7 clks later, busy high 6 clks.
// - Gain/floor: ch0=1000 g12, ch1=-1001 g4, ch2=500 g8 with mute=1 -> audio_out=1500-501=999.
// - Hard clip: all ch=30000 g15, mode 0 -> 32767, clip_flag=1.
//   Then clip_clr -> clip_flag=0. All ch=-30000 -> -32768.
// - Compress: ch0=20000 g8, mode 1 -> 17288, clip_flag=1.
//   ch0=-20000 -> -17288. ch0=16384 -> 16384, clip_flag stays 0 after clear.
// - Side cases: keybeep=1, tape_click=1, channels 0 -> 768.
//   Second ce_sample 3 clks after first -> overrun=1, single valid pulse.
//   Reset asserted mid-ACCUM -> no valid pulse.

Source files
------------

// File: rtl/msx_audio_mixer_pkg.sv
// Shared types and constants for the MSX audio mixer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package msx_audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    SYS,
    LIMIT,
    OUT
  } mixer_state_t;

  typedef enum logic {
    MIX_CLIP,
    MIX_COMPRESS
  } mix_mode_t;

  localparam int KEYBEEP_LEVEL = 512;
  localparam int TAPE_LEVEL    = 256;
  localparam int UNITY_GAIN    = 8;

  // Accumulator width: the product of one channel, plus enough growth bits for
  // CHANNELS terms and the keybeep/tape offsets, plus a sign bit. Overflow is
  // impossible by construction.
  function automatic int mix_acc_width(input int channels, input int in_w, input int gain_w);
    return in_w + gain_w + $clog2(channels + 1) + 1;
  endfunction

endpackage

// File: rtl/msx_audio_mixer_if.sv
// Sample-side bus of the audio mixer: channel inputs and controls in, mixed sample and status out.
// Latency: n/a (wires only).
// Backpressure: none; the mixer ignores ce_sample while busy and reports it on overrun.
// master: sample source / host side.  slave: msx_audio_mixer.
interface msx_audio_mixer_if #(
  parameter int CHANNELS = 4,
  parameter int IN_W     = 16,
  parameter int GAIN_W   = 4,
  parameter int OUT_W    = 16
);

  logic                         ce_sample;
  logic [CHANNELS*IN_W-1:0]     ch_in;
  logic [CHANNELS*GAIN_W-1:0]   ch_gain;
  logic [CHANNELS-1:0]          ch_mute;
  logic                         keybeep;
  logic                         tape_click;
  logic                         mode;
  logic                         clip_clr;
  logic signed [OUT_W-1:0]      audio_out;
  logic                         audio_valid;
  logic                         busy;
  logic                         clip_flag;
  logic                         overrun;

  modport master (
    output ce_sample, ch_in, ch_gain, ch_mute, keybeep, tape_click, mode, clip_clr,
    input  audio_out, audio_valid, busy, clip_flag, overrun
  );

  modport slave (
    input  ce_sample, ch_in, ch_gain, ch_mute, keybeep, tape_click, mode, clip_clr,
    output audio_out, audio_valid, busy, clip_flag, overrun
  );

endinterface

// File: rtl/msx_audio_limiter.sv
// Output limiter: hard clamp (MIX_CLIP) or 4:1 soft knee above |x|=KNEE then clamp (MIX_COMPRESS).
// Latency: combinational.
// Backpressure: none.
// Ports: value_in (signed ACC_W), mode; limited_out (signed OUT_W), changed (limited != value_in).
module msx_audio_limiter
  import msx_audio_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] value_in,
  input  mix_mode_t               mode,
  output logic signed [OUT_W-1:0] limited_out,
  output logic                    changed
);

  localparam logic signed [ACC_W-1:0] MAXP = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MINN = ~MAXP;
  localparam logic        [ACC_W-1:0] KNEE = ACC_W'(64'd1 << (OUT_W - 2));

  logic                    neg;
  logic [ACC_W-1:0]        mag;
  logic [ACC_W-1:0]        comp_mag;
  logic signed [ACC_W-1:0] comp_val;
  logic signed [ACC_W-1:0] pre_clamp;
  logic signed [ACC_W-1:0] clamped;

  always_comb begin
    neg = value_in[ACC_W-1];
    // Compress on the magnitude so +x and -x map to mirror-image results.
    mag = neg ? (~value_in + ACC_W'(1)) : value_in;
    if (mag <= KNEE) begin
      comp_mag = mag;
    end else begin
      comp_mag = KNEE + ((mag - KNEE) >> 2);
    end
    comp_val = neg ? -$signed(comp_mag) : $signed(comp_mag);

    pre_clamp = (mode == MIX_COMPRESS) ? comp_val : value_in;

    if (pre_clamp > MAXP) begin
      clamped = MAXP;
    end else if (pre_clamp < MINN) begin
      clamped = MINN;
    end else begin
      clamped = pre_clamp;
    end

    limited_out = clamped[OUT_W-1:0];
    changed     = (clamped != value_in);
  end

endmodule

// File: rtl/msx_audio_mixer.sv
// Sequential audio mixer: CHANNELS gain/mute-scaled sources plus keybeep/tape click, then limiter.
// Latency: audio_valid pulses in the CHANNELS+3'th clk after the clk carrying the accepted ce_sample.
// Backpressure: none; ce_sample while a mix is running is dropped and latched on sticky overrun.
// Ports: clk, reset (sync, active high), bus (slave modport: samples/gains/mutes/controls in;
//        audio_out, audio_valid, busy, clip_flag, overrun out).
module msx_audio_mixer
  import msx_audio_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IN_W     = 16,
  parameter int GAIN_W   = 4,
  parameter int OUT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  msx_audio_mixer_if.slave   bus
);

  localparam int ACC_W  = mix_acc_width(CHANNELS, IN_W, GAIN_W);
  localparam int PROD_W = IN_W + GAIN_W + 1;
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  mixer_state_t            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  // Inputs captured at acceptance so the sources may change mid-mix.
  logic signed [IN_W-1:0]  in_snap_q   [CHANNELS];
  logic signed [IN_W-1:0]  in_snap_d   [CHANNELS];
  logic [GAIN_W-1:0]       gain_snap_q [CHANNELS];
  logic [GAIN_W-1:0]       gain_snap_d [CHANNELS];
  logic [CHANNELS-1:0]     mute_snap_q, mute_snap_d;
  logic                    keybeep_q, keybeep_d;
  logic                    tape_q, tape_d;
  mix_mode_t               mode_q, mode_d;

  logic signed [OUT_W-1:0] audio_out_q, audio_out_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    clip_q, clip_d;
  logic                    overrun_q, overrun_d;

  // Shared multiplier datapath, fed by the channel index.
  logic signed [IN_W-1:0]  sel_in;
  logic [GAIN_W-1:0]       sel_gain;
  logic                    sel_mute;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sys_add;

  logic signed [OUT_W-1:0] lim_val;
  logic                    lim_chg;
  logic                    clip_set;
  logic                    overrun_set;

  msx_audio_limiter #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_limiter (
    .value_in    (acc_q),
    .mode        (mode_q),
    .limited_out (lim_val),
    .changed     (lim_chg)
  );

  always_comb begin
    sel_in   = in_snap_q[idx_q];
    sel_gain = gain_snap_q[idx_q];
    sel_mute = mute_snap_q[idx_q];
    // Gain is unsigned; the zero-extended signed operand keeps the multiply signed.
    prod     = PROD_W'(sel_in) * PROD_W'($signed({1'b0, sel_gain}));
    // Arithmetic shift: divide by 8, rounding toward minus infinity.
    term     = sel_mute ? '0 : ACC_W'(prod >>> 3);
    sys_add  = (keybeep_q ? ACC_W'(KEYBEEP_LEVEL) : '0) + (tape_q ? ACC_W'(TAPE_LEVEL) : '0);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    in_snap_d   = in_snap_q;
    gain_snap_d = gain_snap_q;
    mute_snap_d = mute_snap_q;
    keybeep_d   = keybeep_q;
    tape_d      = tape_q;
    mode_d      = mode_q;
    audio_out_d = audio_out_q;
    valid_d     = 1'b0;
    clip_set    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ce_sample) begin
          state_d = ACCUM;
          idx_d   = '0;
          acc_d   = '0;
          for (int i = 0; i < CHANNELS; i++) begin
            in_snap_d[i]   = bus.ch_in[i*IN_W +: IN_W];
            gain_snap_d[i] = bus.ch_gain[i*GAIN_W +: GAIN_W];
          end
          mute_snap_d = bus.ch_mute;
          keybeep_d   = bus.keybeep;
          tape_d      = bus.tape_click;
          mode_d      = mix_mode_t'(bus.mode);
        end
      end
      ACCUM: begin
        acc_d = acc_q + term;
        if (idx_q == LAST_IDX) begin
          state_d = SYS;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SYS: begin
        acc_d   = acc_q + sys_add;
        state_d = LIMIT;
      end
      LIMIT: begin
        audio_out_d = lim_val;
        valid_d     = 1'b1;
        clip_set    = lim_chg;
        state_d     = OUT;
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any strobe outside IDLE is dropped, including during the OUT clk.
    overrun_set = bus.ce_sample && (state_q != IDLE);

    // Registered busy rises one clk after acceptance and falls with the OUT clk.
    busy_d = (state_q != IDLE) && (state_d != IDLE);

    // A set event beats a simultaneous clear.
    clip_d    = clip_set    | (clip_q    & ~bus.clip_clr);
    overrun_d = overrun_set | (overrun_q & ~bus.clip_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      in_snap_q   <= '{default: '0};
      gain_snap_q <= '{default: '0};
      mute_snap_q <= '0;
      keybeep_q   <= 1'b0;
      tape_q      <= 1'b0;
      mode_q      <= MIX_CLIP;
      audio_out_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      in_snap_q   <= in_snap_d;
      gain_snap_q <= gain_snap_d;
      mute_snap_q <= mute_snap_d;
      keybeep_q   <= keybeep_d;
      tape_q      <= tape_d;
      mode_q      <= mode_d;
      audio_out_q <= audio_out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.audio_out   = audio_out_q;
  assign bus.audio_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.clip_flag   = clip_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_msx_audio_mixer.sv
// Directed, table-driven bench for msx_audio_mixer at CHANNELS=4, IN_W=16, GAIN_W=4, OUT_W=16.
module tb_msx_audio_mixer;

  localparam int CH = 4;

  logic clk;
  logic reset;

  msx_audio_mixer_if #(.CHANNELS(CH), .IN_W(16), .GAIN_W(4), .OUT_W(16)) bus ();

  msx_audio_mixer #(.CHANNELS(CH), .IN_W(16), .GAIN_W(4), .OUT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         ch[CH];
    int         gain[CH];
    logic [3:0] mute;
    logic       kb;
    logic       tc;
    logic       md;
    int         exp_out;
    logic       exp_clip;
  } vec_t;

  vec_t vecs[$];

  int n_cmp;
  int n_bad;

  int r_valid_at;
  int r_valid_cnt;
  int r_busy_cnt;
  int r_out;
  int r_hold;

  function automatic vec_t mk(input string name,
                              input int c0, input int c1, input int c2, input int c3,
                              input int g0, input int g1, input int g2, input int g3,
                              input logic [3:0] mute, input logic kb, input logic tc,
                              input logic md, input int exp_out, input logic exp_clip);
    vec_t v;
    v.name = name;
    v.ch[0] = c0; v.ch[1] = c1; v.ch[2] = c2; v.ch[3] = c3;
    v.gain[0] = g0; v.gain[1] = g1; v.gain[2] = g2; v.gain[3] = g3;
    v.mute = mute; v.kb = kb; v.tc = tc; v.md = md;
    v.exp_out = exp_out; v.exp_clip = exp_clip;
    return v;
  endfunction

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clip_clr = 1'b1;
    @(negedge clk);
    bus.clip_clr = 1'b0;
  endtask

  // Starts one mix and watches 20 clks. Optional one-clk injections of ce_sample,
  // clip_clr or reset at a given clk offset j (0 = none); j counts clks after the ce clk.
  task automatic run_mix(input vec_t v, input int ce_j, input int clr_j, input int rst_j);
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      bus.ch_in[i*16 +: 16] = 16'(v.ch[i]);
      bus.ch_gain[i*4 +: 4] = 4'(v.gain[i]);
    end
    bus.ch_mute    = v.mute;
    bus.keybeep    = v.kb;
    bus.tape_click = v.tc;
    bus.mode       = v.md;
    bus.ce_sample  = 1'b1;
    r_valid_at  = -1;
    r_valid_cnt = 0;
    r_busy_cnt  = 0;
    r_out       = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      bus.ce_sample = (j == ce_j);
      bus.clip_clr  = (j == clr_j);
      reset         = (j == rst_j);
      if (j == 1) begin
        // Scramble the sources: the mix must use the accepted snapshot.
        bus.ch_in      = {$urandom, $urandom};
        bus.ch_gain    = 16'($urandom);
        bus.ch_mute    = 4'($urandom);
        bus.keybeep    = 1'($urandom);
        bus.tape_click = 1'($urandom);
        bus.mode       = 1'($urandom);
      end
      if (bus.audio_valid === 1'b1) begin
        r_valid_cnt++;
        if (r_valid_at < 0) begin
          r_valid_at = j;
          r_out      = int'(bus.audio_out);
        end
      end
      if (bus.busy === 1'b1) r_busy_cnt++;
    end
    r_hold = int'(bus.audio_out);
    bus.ce_sample = 1'b0;
    bus.clip_clr  = 1'b0;
    reset         = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset          = 1'b1;
    bus.ce_sample  = 1'b0;
    bus.ch_in      = '0;
    bus.ch_gain    = '0;
    bus.ch_mute    = '0;
    bus.keybeep    = 1'b0;
    bus.tape_click = 1'b0;
    bus.mode       = 1'b0;
    bus.clip_clr   = 1'b0;

    //                name         ch0     ch1     ch2     ch3    g0 g1 g2 g3 mute     kb tc md  out     clip
    vecs.push_back(mk("unity",     1000,   0,      0,      0,     8, 0, 0, 0, 4'b0000, 0, 0, 0, 1000,   0));
    vecs.push_back(mk("gain_floor",1000,   -1001,  500,    0,     12,4, 8, 0, 4'b0100, 0, 0, 0, 999,    0));
    vecs.push_back(mk("hclip_pos", 30000,  30000,  30000,  30000, 15,15,15,15,4'b0000, 0, 0, 0, 32767,  1));
    vecs.push_back(mk("hclip_neg", -30000, -30000, -30000, -30000,15,15,15,15,4'b0000, 0, 0, 0, -32768, 1));
    vecs.push_back(mk("comp_pos",  20000,  0,      0,      0,     8, 0, 0, 0, 4'b0000, 0, 0, 1, 17288,  1));
    vecs.push_back(mk("comp_neg",  -20000, 0,      0,      0,     8, 0, 0, 0, 4'b0000, 0, 0, 1, -17288, 1));
    vecs.push_back(mk("comp_knee", 16384,  0,      0,      0,     8, 0, 0, 0, 4'b0000, 0, 0, 1, 16384,  0));
    vecs.push_back(mk("comp_k+1",  16385,  0,      0,      0,     8, 0, 0, 0, 4'b0000, 0, 0, 1, 16384,  1));
    vecs.push_back(mk("comp_k-1",  -16385, 0,      0,      0,     8, 0, 0, 0, 4'b0000, 0, 0, 1, -16384, 1));
    vecs.push_back(mk("comp_17k",  17000,  0,      0,      0,     8, 0, 0, 0, 4'b0000, 0, 0, 1, 16538,  1));
    vecs.push_back(mk("comp_satp", 30000,  30000,  30000,  30000, 15,15,15,15,4'b0000, 0, 0, 1, 32767,  1));
    vecs.push_back(mk("comp_satn", -30000, -30000, -30000, -30000,15,15,15,15,4'b0000, 0, 0, 1, -32768, 1));
    vecs.push_back(mk("sys_both",  0,      0,      0,      0,     0, 0, 0, 0, 4'b0000, 1, 1, 0, 768,    0));
    vecs.push_back(mk("keybeep",   -1000,  0,      0,      0,     8, 0, 0, 0, 4'b0000, 1, 0, 0, -488,   0));
    vecs.push_back(mk("tape",      100,    0,      0,      0,     8, 0, 0, 0, 4'b0000, 0, 1, 0, 356,    0));
    vecs.push_back(mk("edge_max",  32767,  0,      0,      0,     8, 0, 0, 0, 4'b0000, 0, 0, 0, 32767,  0));
    vecs.push_back(mk("edge_min",  -32768, 0,      0,      0,     8, 0, 0, 0, 4'b0000, 0, 0, 0, -32768, 0));
    vecs.push_back(mk("floor_sm",  -3,     0,      0,      0,     1, 0, 0, 0, 4'b0000, 0, 0, 0, -1,     0));
    vecs.push_back(mk("floor_pair",7,      -7,     0,      0,     15,15,0, 0, 4'b0000, 0, 0, 0, -1,     0));
    vecs.push_back(mk("all_muted", 30000,  30000,  30000,  30000, 15,15,15,15,4'b1111, 0, 0, 0, 0,      0));
    vecs.push_back(mk("four_sum",  100,    200,    300,    1001,  8, 8, 8, 3, 4'b0000, 0, 0, 0, 975,    0));

    // Reset held 3 clks with ce_sample toggling: everything stays quiet.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.ce_sample = ~bus.ce_sample;
      check("rst_valid", 32'(bus.audio_valid), 0);
      check("rst_busy",  32'(bus.busy), 0);
      check("rst_out",   32'(bus.audio_out), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.ce_sample = 1'b0;
    @(negedge clk);
    check("post_rst_out",     32'(bus.audio_out), 0);
    check("post_rst_valid",   32'(bus.audio_valid), 0);
    check("post_rst_busy",    32'(bus.busy), 0);
    check("post_rst_clip",    32'(bus.clip_flag), 0);
    check("post_rst_overrun", 32'(bus.overrun), 0);

    foreach (vecs[n]) begin
      pulse_clr();
      check({vecs[n].name, " clip_cleared"}, 32'(bus.clip_flag), 0);
      run_mix(vecs[n], 0, 0, 0);
      check({vecs[n].name, " out"},       r_out, vecs[n].exp_out);
      check({vecs[n].name, " hold"},      r_hold, vecs[n].exp_out);
      check({vecs[n].name, " clip"},      32'(bus.clip_flag), 32'(vecs[n].exp_clip));
      check({vecs[n].name, " valid_at"},  r_valid_at, 7);
      check({vecs[n].name, " valid_cnt"}, r_valid_cnt, 1);
      check({vecs[n].name, " busy_cnt"},  r_busy_cnt, 6);
      check({vecs[n].name, " overrun"},   32'(bus.overrun), 0);
    end

    // Second strobe 3 clks into a mix: dropped, overrun set, single pulse.
    pulse_clr();
    run_mix(vecs[1], 3, 0, 0);
    check("ovr3 overrun",   32'(bus.overrun), 1);
    check("ovr3 valid_cnt", r_valid_cnt, 1);
    check("ovr3 valid_at",  r_valid_at, 7);
    check("ovr3 out",       r_out, 999);

    // Clear works, then a strobe in the OUT clk is also an overrun.
    pulse_clr();
    check("ovr_cleared", 32'(bus.overrun), 0);
    run_mix(vecs[0], 7, 0, 0);
    check("ovr_out overrun",   32'(bus.overrun), 1);
    check("ovr_out valid_cnt", r_valid_cnt, 1);
    check("ovr_out out",       r_out, 1000);

    // Overrun set and clip_clr in the same clk: set wins.
    pulse_clr();
    run_mix(vecs[0], 3, 3, 0);
    check("ovr_vs_clr", 32'(bus.overrun), 1);

    // Clip set in the limiter clk together with clip_clr: set wins.
    pulse_clr();
    run_mix(vecs[2], 0, 6, 0);
    check("clip_vs_clr",     32'(bus.clip_flag), 1);
    check("clip_vs_clr out", r_out, 32767);

    // Reset during ACCUM: no pulse, everything back to zero.
    run_mix(vecs[0], 0, 0, 2);
    check("rst_mid valid_cnt", r_valid_cnt, 0);
    check("rst_mid out",       32'(bus.audio_out), 0);
    check("rst_mid busy",      32'(bus.busy), 0);
    check("rst_mid clip",      32'(bus.clip_flag), 0);
    check("rst_mid overrun",   32'(bus.overrun), 0);

    // Fresh mix after the abandoned one.
    run_mix(vecs[1], 0, 0, 0);
    check("after_rst out",      r_out, 999);
    check("after_rst valid_at", r_valid_at, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
